// File: rtl/tdm_demux_4.sv
// Four-channel TDM demultiplexer: aligns to a frame sync and publishes each complete
// frame to four output registers. All four registers update on the same clock edge.
//
// state  | meaning
// HUNT   | waiting for an FSYNC beat; non-sync beats are dropped silently
// LOCKED | aligned; CNT is the channel index that the next beat is stored to
module tdm_demux_4 #(
    parameter int DATA_W = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic [DATA_W-1:0] i_DATA,
    input  logic              i_VALID,
    input  logic              i_FSYNC,
    output logic [DATA_W-1:0] o_CH0,
    output logic [DATA_W-1:0] o_CH1,
    output logic [DATA_W-1:0] o_CH2,
    output logic [DATA_W-1:0] o_CH3,
    output logic              o_FRAME_VALID,
    output logic [1:0]        o_SEL,
    output logic              o_LOCKED,
    output logic              o_SYNC_ERR
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] stage0_q, stage1_q, stage2_q;
    logic [DATA_W-1:0] stage0_d, stage1_d, stage2_d;
    logic [DATA_W-1:0] ch0_q, ch1_q, ch2_q, ch3_q;
    logic [DATA_W-1:0] ch0_d, ch1_d, ch2_d, ch3_d;
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;
    logic              locked_q, locked_d;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q       <= HUNT;
            cnt_q         <= 2'd0;
            stage0_q      <= '0;
            stage1_q      <= '0;
            stage2_q      <= '0;
            ch0_q         <= '0;
            ch1_q         <= '0;
            ch2_q         <= '0;
            ch3_q         <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage0_q      <= stage0_d;
            stage1_q      <= stage1_d;
            stage2_q      <= stage2_d;
            ch0_q         <= ch0_d;
            ch1_q         <= ch1_d;
            ch2_q         <= ch2_d;
            ch3_q         <= ch3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stage0_d      = stage0_q;
        stage1_d      = stage1_q;
        stage2_d      = stage2_q;
        ch0_d         = ch0_q;
        ch1_d         = ch1_q;
        ch2_d         = ch2_q;
        ch3_d         = ch3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (i_VALID) begin
            case (state_q)
                HUNT: begin
                    if (i_FSYNC) begin
                        stage0_d = i_DATA;
                        cnt_d    = 2'd1;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (i_FSYNC) begin
                        // Sync mid-frame restarts the frame; the partial stage is simply overwritten.
                        sync_err_d = (cnt_q != 2'd0);
                        stage0_d   = i_DATA;
                        cnt_d      = 2'd1;
                    end else begin
                        case (cnt_q)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                state_d    = HUNT;
                                cnt_d      = 2'd0;
                            end
                            2'd1: begin
                                stage1_d = i_DATA;
                                cnt_d    = 2'd2;
                            end
                            2'd2: begin
                                stage2_d = i_DATA;
                                cnt_d    = 2'd3;
                            end
                            default: begin
                                ch0_d         = stage0_q;
                                ch1_d         = stage1_q;
                                ch2_d         = stage2_q;
                                ch3_d         = i_DATA;
                                frame_valid_d = 1'b1;
                                cnt_d         = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = 2'd0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    assign o_CH0         = ch0_q;
    assign o_CH1         = ch1_q;
    assign o_CH2         = ch2_q;
    assign o_CH3         = ch3_q;
    assign o_FRAME_VALID = frame_valid_q;
    assign o_SYNC_ERR    = sync_err_q;
    assign o_SEL         = cnt_q;
    assign o_LOCKED      = locked_q;

endmodule
